// File: rtl/draw_background_anim_if.sv
// Video timing and colour bus shared by the blocks of the drawing chain.
// Modport 'in' receives a stage's upstream signals and 'out' drives the
// downstream ones. master/slave are the same directions under generic names.
interface draw_background_anim_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_background_anim.sv
// Animated background stage for the drawing chain. It paints blanking black,
// a fence, a scrolling cloud, and sky or grass. The sky colour cycles
// DAY -> DUSK -> NIGHT -> DAWN. Animation state moves only on the
// rising edge of vblnk, so every visible frame uses one colour and one cloud
// position. Output is one clock behind the input.
module draw_background_anim #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          HORIZON_Y   = 668,
  parameter int          FENCE_X0    = 497,
  parameter int          FENCE_X1    = 527,
  parameter int          FENCE_Y0    = 384,
  parameter int          FENCE_Y1    = 743,
  parameter logic [11:0] FENCE_RGB   = 12'h977,
  parameter logic [11:0] GRASS_RGB   = 12'h5c5,
  parameter logic [11:0] CLOUD_RGB   = 12'hfff,
  parameter logic [11:0] SKY_DAY     = 12'hadf,
  parameter logic [11:0] SKY_NIGHT   = 12'h114,
  parameter int          HOLD_FRAMES = 600,
  parameter int          STEP_FRAMES = 4,
  parameter int          CLOUD_Y0    = 100,
  parameter int          CLOUD_Y1    = 140,
  parameter int          CLOUD_W     = 64,
  parameter int          CLOUD_SPEED = 1
) (
  input  logic                    clk60MHz,
  input  logic                    rst,
  input  logic                    freeze,
  draw_background_anim_if.in      in,
  draw_background_anim_if.out     out,
  output logic [11:0]             sky_rgb,
  output logic [1:0]              phase
);

  localparam logic [1:0] DAY   = 2'd0;
  localparam logic [1:0] DUSK  = 2'd1;
  localparam logic [1:0] NIGHT = 2'd2;
  localparam logic [1:0] DAWN  = 2'd3;

  // The frame counter must hold the largest of HOLD_FRAMES-1 and STEP_FRAMES-1.
  localparam int CNT_MAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);

  localparam logic [10:0] FX0 = 11'(FENCE_X0);
  localparam logic [10:0] FX1 = 11'(FENCE_X1);
  localparam logic [10:0] FY0 = 11'(FENCE_Y0);
  localparam logic [10:0] FY1 = 11'(FENCE_Y1);
  localparam logic [10:0] CY0 = 11'(CLOUD_Y0);
  localparam logic [10:0] CY1 = 11'(CLOUD_Y1);
  localparam logic [10:0] HOR = 11'(HORIZON_Y);

  // The cloud wrap arithmetic is done 12 bits wide so hcount + H_ACTIVE cannot overflow.
  localparam logic [11:0] H_ACT12   = 12'(H_ACTIVE);
  localparam logic [11:0] SPEED12   = 12'(CLOUD_SPEED);
  localparam logic [11:0] CLOUD_W12 = 12'(CLOUD_W);

  // Move each 4-bit channel of cur one unit toward tgt, saturating at tgt.
  function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] res;
    res = cur;
    for (int i = 0; i < 3; i++) begin
      if (cur[4*i +: 4] < tgt[4*i +: 4]) begin
        res[4*i +: 4] = cur[4*i +: 4] + 4'd1;
      end else if (cur[4*i +: 4] > tgt[4*i +: 4]) begin
        res[4*i +: 4] = cur[4*i +: 4] - 4'd1;
      end else begin
        res[4*i +: 4] = cur[4*i +: 4];
      end
    end
    return res;
  endfunction

  logic             vblnk_d;
  logic [CNT_W-1:0] frame_cnt;
  logic [10:0]      cloud_x;

  logic             tick_s;
  logic [11:0]      sky_tgt_s;
  logic [11:0]      sky_step_s;
  logic [11:0]      cloud_sum_s;
  logic [11:0]      cloud_nxt_s;
  logic [11:0]      off_raw_s;
  logic [11:0]      off_one_s;
  logic [11:0]      off_s;
  logic             in_fence_s;
  logic             in_cloud_s;
  logic [11:0]      pix_s;

  // The upstream colour is replaced entirely by this first stage of the chain.
  logic unused_in_rgb;
  assign unused_in_rgb = ^in.rgb;

  // Frame tick: the first cycle of vblnk, unless animation is frozen.
  always_comb begin
    tick_s = in.vblnk & ~vblnk_d & ~freeze;
  end

  // Next sky colour: one step toward night in DUSK, toward day otherwise.
  always_comb begin
    if (phase == DUSK) begin
      sky_tgt_s = SKY_NIGHT;
    end else begin
      sky_tgt_s = SKY_DAY;
    end
    sky_step_s = step_toward(sky_rgb, sky_tgt_s);
  end

  // Next cloud position, wrapped into 0..H_ACTIVE-1.
  always_comb begin
    cloud_sum_s = {1'b0, cloud_x} + SPEED12;
    if (cloud_sum_s >= H_ACT12) begin
      cloud_nxt_s = cloud_sum_s - H_ACT12;
    end else begin
      cloud_nxt_s = cloud_sum_s;
    end
  end

  // Per-pixel colour choice, highest priority first.
  always_comb begin
    // (hcount - cloud_x) mod H_ACTIVE without negatives; two folds cover hcount < 2*H_ACTIVE.
    off_raw_s = {1'b0, in.hcount} + H_ACT12 - {1'b0, cloud_x};
    if (off_raw_s >= H_ACT12) begin
      off_one_s = off_raw_s - H_ACT12;
    end else begin
      off_one_s = off_raw_s;
    end
    if (off_one_s >= H_ACT12) begin
      off_s = off_one_s - H_ACT12;
    end else begin
      off_s = off_one_s;
    end

    in_fence_s = (in.hcount >= FX0) && (in.hcount <= FX1) &&
                 (in.vcount >= FY0) && (in.vcount <= FY1);
    in_cloud_s = (in.vcount >= CY0) && (in.vcount <= CY1) && (off_s < CLOUD_W12);

    if (in.vblnk || in.hblnk) begin
      pix_s = 12'h000;
    end else if (in_fence_s) begin
      pix_s = FENCE_RGB;
    end else if (in_cloud_s) begin
      pix_s = CLOUD_RGB;
    end else if (in.vcount <= HOR) begin
      pix_s = sky_rgb;
    end else begin
      pix_s = GRASS_RGB;
    end
  end

  // Output stage: delayed timing plus the colour chosen for the same pixel.
  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      out.hcount <= 11'd0;
      out.vcount <= 11'd0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= 12'h000;
    end else begin
      out.hcount <= in.hcount;
      out.vcount <= in.vcount;
      out.hsync  <= in.hsync;
      out.vsync  <= in.vsync;
      out.hblnk  <= in.hblnk;
      out.vblnk  <= in.vblnk;
      out.rgb    <= pix_s;
    end
  end

  // Previous vblnk. This tracks even while frozen, so releasing freeze mid-vblank cannot cause a tick.
  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= in.vblnk;
    end
  end

  // Sky phase sequencer and cloud scroll. They advance only on frame ticks.
  always_ff @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      phase     <= DAY;
      sky_rgb   <= SKY_DAY;
      frame_cnt <= {CNT_W{1'b0}};
      cloud_x   <= 11'd0;
    end else if (tick_s) begin
      cloud_x <= cloud_nxt_s[10:0];
      case (phase)
        DAY: begin
          if (frame_cnt == HOLD_LAST) begin
            frame_cnt <= {CNT_W{1'b0}};
            phase     <= DUSK;
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        DUSK: begin
          if (frame_cnt == STEP_LAST) begin
            frame_cnt <= {CNT_W{1'b0}};
            sky_rgb   <= sky_step_s;
            if (sky_step_s == SKY_NIGHT) begin
              phase <= NIGHT;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        NIGHT: begin
          if (frame_cnt == HOLD_LAST) begin
            frame_cnt <= {CNT_W{1'b0}};
            phase     <= DAWN;
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        DAWN: begin
          if (frame_cnt == STEP_LAST) begin
            frame_cnt <= {CNT_W{1'b0}};
            sky_rgb   <= sky_step_s;
            if (sky_step_s == SKY_DAY) begin
              phase <= DAY;
            end
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          phase     <= DAY;
          sky_rgb   <= SKY_DAY;
          frame_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_background_anim.sv
// Directed bench for draw_background_anim with HOLD_FRAMES=2 and STEP_FRAMES=1.
// A frame-level model predicts every output on every cycle. Hand-computed
// literals at key points pin the model to known values.
module tb_draw_background_anim;

  localparam int HOLD = 2;
  localparam int STEP = 1;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic        freeze;
  logic [11:0] sky_rgb;
  logic [1:0]  phase;

  draw_background_anim_if vin ();
  draw_background_anim_if vout ();

  draw_background_anim #(.HOLD_FRAMES(HOLD), .STEP_FRAMES(STEP)) dut (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .freeze   (freeze),
    .in       (vin),
    .out      (vout),
    .sky_rgb  (sky_rgb),
    .phase    (phase)
  );

  always #8 clk60MHz = ~clk60MHz;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: channels as integers, phase 0..3, tick counter within the phase.
  int m_ch[3];
  int m_phase;
  int m_cnt;
  int m_cloud;
  bit m_vprev;
  logic [31:0] e_rgb, e_h, e_v, e_hs, e_vs, e_hb, e_vb;

  function automatic int day_ch(input int i);
    int v[3] = '{10, 13, 15};
    return v[i];
  endfunction

  function automatic int night_ch(input int i);
    int v[3] = '{1, 1, 4};
    return v[i];
  endfunction

  function automatic int m_sky();
    return m_ch[0] * 256 + m_ch[1] * 16 + m_ch[2];
  endfunction

  function automatic int pixel(input int h, input int v, input bit hb, input bit vb,
                               input int sky, input int cx);
    if (hb || vb) return 0;
    if (h >= 497 && h <= 527 && v >= 384 && v <= 743) return 'h977;
    if (v >= 100 && v <= 140 && ((h - cx + 1024) % 1024) < 64) return 'hfff;
    if (v <= 668) return sky;
    return 'h5c5;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_ch[i] = day_ch(i);
    m_phase = 0; m_cnt = 0; m_cloud = 0; m_vprev = 1'b0;
    e_rgb = 0; e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
  endtask

  task automatic m_advance();
    bit done;
    int tgt;
    m_cloud = (m_cloud + 1) % 1024;
    m_cnt++;
    if (m_phase == 0 || m_phase == 2) begin
      if (m_cnt == HOLD) begin
        m_cnt = 0;
        m_phase = m_phase + 1;
      end
    end else if (m_cnt == STEP) begin
      m_cnt = 0;
      done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tgt = (m_phase == 1) ? night_ch(i) : day_ch(i);
        if (m_ch[i] < tgt) m_ch[i]++;
        else if (m_ch[i] > tgt) m_ch[i]--;
        if (m_ch[i] != tgt) done = 1'b0;
      end
      if (done) m_phase = (m_phase + 1) % 4;
    end
  endtask

  initial m_reset();

  // Model update: predict the next outputs from the inputs sampled on this edge.
  always @(posedge clk60MHz or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      e_rgb = pixel(int'(vin.hcount), int'(vin.vcount), vin.hblnk, vin.vblnk, m_sky(), m_cloud);
      e_h = vin.hcount; e_v = vin.vcount; e_hs = vin.hsync; e_vs = vin.vsync;
      e_hb = vin.hblnk; e_vb = vin.vblnk;
      if (vin.vblnk && !m_vprev && !freeze) m_advance();
      m_vprev = vin.vblnk;
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk60MHz) begin
    if (chk_en) begin
      check("rgb",    vout.rgb,    e_rgb);
      check("hcount", vout.hcount, e_h);
      check("vcount", vout.vcount, e_v);
      check("hsync",  vout.hsync,  e_hs);
      check("vsync",  vout.vsync,  e_vs);
      check("hblnk",  vout.hblnk,  e_hb);
      check("vblnk",  vout.vblnk,  e_vb);
      check("sky",    sky_rgb,     m_sky());
      check("phase",  phase,       m_phase);
    end
  end

  task automatic drive(input int h, input int v, input bit hb, input bit vb);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hb;
    vin.vsync  = vb;
    vin.rgb    = 12'(h);
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic pix(input string name, input int h, input int v, input bit hb,
                     input bit vb, input int exp);
    drive(h, v, hb, vb);
    @(negedge clk60MHz);
    check(name, vout.rgb, exp);
  endtask

  task automatic tick_frame();
    drive(0, 770, 1'b1, 1'b1);
    drive(100, 200, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    freeze = 1'b1;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'h000;
    repeat (3) @(posedge clk60MHz);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Static picture at frame 0, animation frozen.
    pix("fence",   510, 400, 1'b0, 1'b0, 'h977);
    pix("cloud",    10, 120, 1'b0, 1'b0, 'hfff);
    pix("sky",     200, 300, 1'b0, 1'b0, 'hadf);
    pix("grass",   200, 700, 1'b0, 1'b0, 'h5c5);
    pix("hblank",  510, 400, 1'b1, 1'b0, 'h000);
    pix("vblank",   10, 120, 1'b0, 1'b1, 'h000);
    pix("horizon", 200, 668, 1'b0, 1'b0, 'hadf);
    pix("below",   200, 669, 1'b0, 1'b0, 'h5c5);
    repeat (3) tick_frame();
    check("frozen_sky", sky_rgb, 'hadf);
    check("frozen_phase", phase, 0);
    pix("cloud_edge", 63, 120, 1'b0, 1'b0, 'hfff);
    pix("past_cloud", 64, 120, 1'b0, 1'b0, 'hadf);

    // Full colour cycle with HOLD=2, STEP=1.
    freeze = 1'b0;
    repeat (2) tick_frame();
    check("to_dusk", phase, 1);
    check("dusk_start_sky", sky_rgb, 'hadf);
    tick_frame();
    check("first_step", sky_rgb, 'h9ce);
    repeat (11) tick_frame();
    check("night_sky", sky_rgb, 'h114);
    check("night_phase", phase, 2);
    repeat (2) tick_frame();
    check("dawn_phase", phase, 3);
    repeat (12) tick_frame();
    check("day_sky", sky_rgb, 'hadf);
    check("day_phase", phase, 0);

    // Freeze in DUSK: nothing moves, then resumes.
    repeat (3) tick_frame();
    check("dusk_again", sky_rgb, 'h9ce);
    freeze = 1'b1;
    repeat (50) tick_frame();
    check("freeze_sky", sky_rgb, 'h9ce);
    check("freeze_phase", phase, 1);
    freeze = 1'b0;
    tick_frame();
    check("resume_sky", sky_rgb, 'h8bd);
    pix("cloud_x32_in",  32, 120, 1'b0, 1'b0, 'hfff);
    pix("cloud_x32_out", 31, 120, 1'b0, 1'b0, 'h8bd);
    pix("cloud_x32_end", 95, 120, 1'b0, 1'b0, 'hfff);
    pix("cloud_x32_aft", 96, 120, 1'b0, 1'b0, 'h8bd);

    // Asynchronous reset during DUSK, mid-line.
    drive(300, 200, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_rgb", vout.rgb, 0);
    check("rst_hcount", vout.hcount, 0);
    check("rst_sky", sky_rgb, 'hadf);
    check("rst_phase", phase, 0);
    @(posedge clk60MHz);
    #1;
    rst = 1'b1;
    tick_frame();
    check("hold_restart1", phase, 0);
    tick_frame();
    check("hold_restart2", phase, 1);

    // Cloud wrap at cloud_x = 1000, 1000 ticks after reset.
    repeat (998) tick_frame();
    freeze = 1'b1;
    check("wrap_phase", phase, 3);
    check("wrap_sky", sky_rgb, 'h558);
    pix("wrap_1000",  1000, 120, 1'b0, 1'b0, 'hfff);
    pix("wrap_1023",  1023, 120, 1'b0, 1'b0, 'hfff);
    pix("wrap_0",        0, 120, 1'b0, 1'b0, 'hfff);
    pix("wrap_39",      39, 120, 1'b0, 1'b0, 'hfff);
    pix("wrap_40",      40, 120, 1'b0, 1'b0, 'h558);
    pix("wrap_999",    999, 120, 1'b0, 1'b0, 'h558);
    pix("wrap_row141", 1000, 141, 1'b0, 1'b0, 'h558);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_background_anim.md
Name: draw_background_anim

Overview:
- Parametrised, animated successor to the static background drawer. Sits first in the vga_if drawing chain, right after the timing generator.
- Paints, in priority order: blanking black, fence, scrolling cloud, then sky or grass.
- The sky colour cycles DAY -> DUSK -> NIGHT -> DAWN, one colour step per frame tick. All animation state updates only at frame boundaries, so a frame never tears.

Parameters:
- H_ACTIVE, 1024: active width in pixels; cloud x wraps modulo this.
- HORIZON_Y, 668: rows <= HORIZON_Y are sky; rows below are grass.
- FENCE_X0, 497 / FENCE_X1, 527: fence column bounds, inclusive.
- FENCE_Y0, 384 / FENCE_Y1, 743: fence row bounds, inclusive.
- FENCE_RGB, 12'h977; GRASS_RGB, 12'h5c5; CLOUD_RGB, 12'hfff.
- SKY_DAY, 12'hadf / SKY_NIGHT, 12'h114: sky end-point colours.
- HOLD_FRAMES, 600: frames spent in DAY and in NIGHT.
- STEP_FRAMES, 4: frames between colour steps in DUSK and DAWN.
- CLOUD_Y0, 100 / CLOUD_Y1, 140: cloud rows, inclusive. Must be <= HORIZON_Y.
- CLOUD_W, 64: cloud width in pixels.
- CLOUD_SPEED, 1: cloud x advance per frame tick.

Ports:
- clk60MHz  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  1 = hold all animation state.
- in  vga_if.in  -  timing and rgb from upstream (hcount/vcount 11b, rgb 12b).
- out  vga_if.out  -  registered timing plus generated rgb.
- sky_rgb  out  12  current sky colour, for downstream blocks.
- phase  out  2  0=DAY, 1=DUSK, 2=NIGHT, 3=DAWN.

Behaviour:
- Reset (rst low, asynchronous):
  - All out.* fields, including rgb, go to 0.
  - sky_rgb = SKY_DAY, phase = DAY.
  - Frame counter = 0, cloud_x = 0, vblnk_d = 0.
- Pipeline latency is 1 clock. out timing fields are in.* delayed by one cycle; out.rgb is the colour computed from the same-cycle in.*.
- Frame tick: in.vblnk high while vblnk_d low (vblnk_d is registered in.vblnk). Exactly one tick per frame.
- Ticks are ignored while freeze = 1. Timing pass-through and drawing continue unaffected.
- Pixel colour, highest priority first:
  1. in.vblnk or in.hblnk -> 12'h000.
  2. Inside the fence rectangle (inclusive bounds) -> FENCE_RGB.
  3. vcount within CLOUD_Y0..CLOUD_Y1 and ((hcount - cloud_x) mod H_ACTIVE) < CLOUD_W -> CLOUD_RGB. The cloud wraps across the right edge.
  4. vcount <= HORIZON_Y -> sky_rgb register value.
  5. Otherwise -> GRASS_RGB.
- State machine (evaluated on unfrozen ticks only):
  - DAY: count ticks. At count == HOLD_FRAMES-1, clear the count and go to DUSK.
  - DUSK: every STEP_FRAMES ticks, move each 4-bit channel of sky_rgb one unit toward SKY_NIGHT; a channel already equal does not change. When all channels equal SKY_NIGHT after the step, go to NIGHT and clear the count.
  - NIGHT: hold HOLD_FRAMES ticks, then go to DAWN.
  - DAWN: mirror of DUSK toward SKY_DAY, then go to DAY.
  - Channel arithmetic is unsigned 4-bit and never overflows or underflows.
- Cloud: on each unfrozen tick, cloud_x <= (cloud_x + CLOUD_SPEED) mod H_ACTIVE. Width is 11b; the wrap compare uses at least 12b.
- sky_rgb and cloud_x change only on the tick cycle, which falls inside vertical blanking. Active pixels within a frame use a constant colour and position.
- Reset mid-frame takes effect immediately. After release, out.* resumes from the next in.* sample.
- Edge cases:
  - HOLD_FRAMES = 1: one tick per hold phase.
  - SKY_DAY == SKY_NIGHT: DUSK and DAWN each take exactly one step interval.

Test Plan:
1. Assert rst low mid-line -> out.rgb = 0, out.hcount = 0, sky_rgb = 12'hadf, phase = 0 asynchronously, before the next clock edge.
2. Default parameters, frame 0, freeze = 1:
   - (hcount, vcount) = (510, 400) -> 12'h977.
   - (10, 120) -> 12'hfff.
   - (200, 300) -> 12'hadf.
   - (200, 700) -> 12'h5c5.
   - any blanked pixel -> 12'h000.
   - Each out.rgb appears 1 clock after its inputs.
3. HOLD_FRAMES = 2, STEP_FRAMES = 1:
   - phase goes to DUSK after 2 ticks.
   - sky_rgb after the first step = 12'h9ce.
   - NIGHT (12'h114) is reached after 12 steps (max channel delta d->1 = 12).
   - DAWN then returns to 12'hadf and DAY.
4. Cloud wrap, cloud_x = 1000 after 1000 ticks: row 120 shows cloud at hcount 1000..1023 and 0..39, and sky at hcount 40.
5. freeze = 1 for 50 frames in DUSK -> sky_rgb, phase, and cloud_x unchanged. Releasing freeze resumes from the same counter value.
6. Pulse rst during DUSK at frame 3 -> after release, phase = DAY, sky_rgb = 12'hadf, and the DAY hold count restarts at 0.
